oflow_score_board: RTL

Per-frame candidate store between the PE array and the conflict-resolution stage. During LOAD the PEs write one match entry per (PE, row): best candidate and fallback candidate, each with score and ID. Control then passes to conflict resolution with a one-cycle `start_cr` pulse. During CR the block serves combinational score/ID reads and accepts 1-bit pointer writes that switch an entry from its best to its fallback candidate. The frame closes on `done_cr`.

---
 rtl/oflow_score_board.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/oflow_score_board.sv
// oflow_score_board: per-frame candidate store between the PE array and the
// conflict-resolution (CR) stage.
//
// Frame flow: IDLE -(start_load)-> LOAD -(load_done)-> CR -(done_cr)-> DONE -> IDLE
//
// Ports
//   clk, reset                   clock, async active-high reset
//   start_load                   open a frame (honoured in IDLE only)
//   wr_valid / wr_ready          entry write strobe / accepted (high in LOAD)
//   wr_pe, wr_row                entry address
//   wr_score_best, wr_id_best    best candidate
//   wr_score_fb, wr_id_fb,
//   wr_fb_valid                  fallback candidate + valid
//   load_done                    PEs finished writing
//   start_cr                     one-cycle pulse on the first CR cycle
//   done_cr                      resolver finished
//   frame_done                   one-cycle pulse in DONE
//   pe_sel, row_sel              combinational read address
//   score_to_cr, id_to_cr        read data (all-ones / 0 for an invalid pick)
//   pe_to_change, row_to_change,
//   data_to_score_board,
//   write_to_pointer             best/fallback pointer write port (CR only)
//   valid_count                  number of valid entries (saturating)
//   overwrite_err                sticky: a valid entry was rewritten in LOAD
//
// Build option: OFLOW_SCORE_BOARD_FALLBACK_EN builds the fallback storage and
// the pointer. Without it the fallback inputs and pointer port are ignored
// and reads always return the best candidate.
module oflow_score_board #(
  parameter int NUM_PE    = 8,
  parameter int ROWS      = 16,
  parameter int SCORE_LEN = 16,
  parameter int ID_LEN    = 12,
  localparam int PE_LEN   = $clog2(NUM_PE),
  localparam int ROW_LEN  = $clog2(ROWS),
  localparam int CNT_LEN  = $clog2(NUM_PE*ROWS) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_load,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [PE_LEN-1:0]    wr_pe,
  input  logic [ROW_LEN-1:0]   wr_row,
  input  logic [SCORE_LEN-1:0] wr_score_best,
  input  logic [ID_LEN-1:0]    wr_id_best,
  input  logic [SCORE_LEN-1:0] wr_score_fb,
  input  logic [ID_LEN-1:0]    wr_id_fb,
  input  logic                 wr_fb_valid,
  input  logic                 load_done,
  output logic                 start_cr,
  input  logic                 done_cr,
  output logic                 frame_done,
  input  logic [PE_LEN-1:0]    pe_sel,
  input  logic [ROW_LEN-1:0]   row_sel,
  output logic [SCORE_LEN-1:0] score_to_cr,
  output logic [ID_LEN-1:0]    id_to_cr,
  input  logic [PE_LEN-1:0]    pe_to_change,
  input  logic [ROW_LEN-1:0]   row_to_change,
  input  logic                 data_to_score_board,
  input  logic                 write_to_pointer,
  output logic [CNT_LEN-1:0]   valid_count,
  output logic                 overwrite_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] CR   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [CNT_LEN-1:0] MAX_CNT = CNT_LEN'(NUM_PE*ROWS);

  logic [1:0] state;

  // flop-based entry storage, [pe][row]
  logic [NUM_PE-1:0][ROWS-1:0]                valid_best;
  logic [NUM_PE-1:0][ROWS-1:0][SCORE_LEN-1:0] score_best;
  logic [NUM_PE-1:0][ROWS-1:0][ID_LEN-1:0]    id_best;
`ifdef OFLOW_SCORE_BOARD_FALLBACK_EN
  logic [NUM_PE-1:0][ROWS-1:0]                valid_fb;
  logic [NUM_PE-1:0][ROWS-1:0]                ptr;
  logic [NUM_PE-1:0][ROWS-1:0][SCORE_LEN-1:0] score_fb;
  logic [NUM_PE-1:0][ROWS-1:0][ID_LEN-1:0]    id_fb;
`else
  logic unused_fb;
  assign unused_fb = ^{wr_score_fb, wr_id_fb, wr_fb_valid, pe_to_change,
                       row_to_change, data_to_score_board, write_to_pointer};
`endif

  assign wr_ready   = (state == LOAD);
  assign frame_done = (state == DONE);

  // control state, valid flags, pointer, counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      valid_best    <= '0;
      valid_count   <= '0;
      overwrite_err <= 1'b0;
      start_cr      <= 1'b0;
`ifdef OFLOW_SCORE_BOARD_FALLBACK_EN
      valid_fb      <= '0;
      ptr           <= '0;
`endif
    end else begin
      start_cr <= (state == LOAD) && load_done;
      case (state)
        IDLE: if (start_load) begin
          valid_best    <= '0;
          valid_count   <= '0;
          overwrite_err <= 1'b0;
`ifdef OFLOW_SCORE_BOARD_FALLBACK_EN
          valid_fb      <= '0;
          ptr           <= '0;
`endif
          state         <= LOAD;
        end
        LOAD: begin
          // a write coinciding with load_done is still taken
          if (wr_valid) begin
            valid_best[wr_pe][wr_row] <= 1'b1;
            if (valid_best[wr_pe][wr_row])
              overwrite_err <= 1'b1;
            else if (valid_count != MAX_CNT)
              valid_count <= valid_count + 1'b1;
`ifdef OFLOW_SCORE_BOARD_FALLBACK_EN
            valid_fb[wr_pe][wr_row] <= wr_fb_valid;
            ptr[wr_pe][wr_row]      <= 1'b0;
`endif
          end
          if (load_done) state <= CR;
        end
        CR: begin
`ifdef OFLOW_SCORE_BOARD_FALLBACK_EN
          // never point at a missing candidate
          if (write_to_pointer && valid_best[pe_to_change][row_to_change] &&
              (!data_to_score_board || valid_fb[pe_to_change][row_to_change]))
            ptr[pe_to_change][row_to_change] <= data_to_score_board;
`endif
          if (done_cr) state <= DONE;
        end
        default: state <= IDLE;  // DONE
      endcase
    end
  end

  // candidate payload; qualified by the valid flags so no reset needed
  always_ff @(posedge clk) begin
    if (state == LOAD && wr_valid) begin
      score_best[wr_pe][wr_row] <= wr_score_best;
      id_best[wr_pe][wr_row]    <= wr_id_best;
`ifdef OFLOW_SCORE_BOARD_FALLBACK_EN
      score_fb[wr_pe][wr_row]   <= wr_score_fb;
      id_fb[wr_pe][wr_row]      <= wr_id_fb;
`endif
    end
  end

  // combinational read; a same-cycle pointer write is seen next cycle
  always_comb begin
    score_to_cr = '1;
    id_to_cr    = '0;
`ifdef OFLOW_SCORE_BOARD_FALLBACK_EN
    if (ptr[pe_sel][row_sel]) begin
      if (valid_fb[pe_sel][row_sel]) begin
        score_to_cr = score_fb[pe_sel][row_sel];
        id_to_cr    = id_fb[pe_sel][row_sel];
      end
    end else
`endif
    if (valid_best[pe_sel][row_sel]) begin
      score_to_cr = score_best[pe_sel][row_sel];
      id_to_cr    = id_best[pe_sel][row_sel];
    end
  end

endmodule
